// File: rtl/in_port_pkg.sv
// in_port_pkg: shared defaults and width helpers for the input-port buffer.
package in_port_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 8;
  function automatic int ptr_w(input int depth);
    return depth > 1 ? $clog2(depth) : 1;
  endfunction
  localparam int DEF_CNT_W = ptr_w(DEF_DEPTH) + 1;
endpackage

// File: rtl/in_port_fifo_mem.sv
// in_port_fifo_mem: DEPTH x WIDTH register array, one write port, async read port.
module in_port_fifo_mem #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int PW = 3
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PW-1:0]    wa,
  input  logic [WIDTH-1:0] wd,
  input  logic [PW-1:0]    ra,
  output logic [WIDTH-1:0] rd
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk) if (we) mem[wa] <= wd;
  assign rd = mem[ra];
endmodule

// File: rtl/in_port_buffer.sv
// in_port_buffer: FWFT input-port FIFO feeding the datapath IN port with sticky error flags.
// Define IN_PORT_HOLD_LAST_EN to keep the last popped word on INdata while empty.
module in_port_buffer
  import in_port_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                      Clock,
  input  logic                      GlobalReset,
  input  logic [WIDTH-1:0]          ExtData,
  input  logic                      ExtValid,
  output logic                      ExtReady,
  input  logic                      INpop,
  output logic [WIDTH-1:0]          INdata,
  output logic                      INvalid,
  output logic [$clog2(DEPTH):0]    Count,
  input  logic                      ClearFlags,
  output logic                      Overflow,
  output logic                      Underflow
);
  localparam int PW = ptr_w(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] rd_data;
  logic full, empty, push, pop, ovf, udf;
  assign full  = cnt == CW'(DEPTH);
  assign empty = cnt == '0;
  assign push  = ExtValid & ~full;
  assign pop   = INpop & ~empty;
  in_port_fifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PW(PW)) u_mem (
    .clk(Clock),
    .we (push),
    .wa (wr_ptr),
    .wd (ExtData),
    .ra (rd_ptr),
    .rd (rd_data)
  );
  always_ff @(posedge Clock or negedge GlobalReset) begin
    if (!GlobalReset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + CW'(push) - CW'(pop);
      ovf <= (ovf & ~ClearFlags) | (ExtValid & full);
      udf <= (udf & ~ClearFlags) | (INpop & empty);
    end
  end
`ifdef IN_PORT_HOLD_LAST_EN
  logic [WIDTH-1:0] last;
  always_ff @(posedge Clock or negedge GlobalReset) begin
    if (!GlobalReset) last <= '0;
    else if (pop) last <= rd_data;
  end
  assign INdata = empty ? last : rd_data;
`else
  assign INdata = empty ? '0 : rd_data;
`endif
  assign ExtReady  = ~full;
  assign INvalid   = ~empty;
  assign Count     = cnt;
  assign Overflow  = ovf;
  assign Underflow = udf;
endmodule
